// File: rtl/axis_tbcall_queue_if.sv
// Host-side call handshake: the queue presents its head call, the host acknowledges it.
interface axis_tbcall_queue_if #(
   parameter int IDW  = 2,
   parameter int ARGW = 32
);
   logic            valid;
   logic [IDW-1:0]  id;
   logic [ARGW-1:0] arg;
   logic            ack;

   modport master (output valid, id, arg, input ack);
   modport slave  (input valid, id, arg, output ack);
endinterface

// File: rtl/axis_tbcall_queue.sv
// Task-call sequencer: captures call edges per source, queues them in order and holds the
// emulated design stopped while any call is pending or being served by the host.
module axis_tbcall_queue #(
   parameter int NCALL   = 4,
   parameter int ARGW    = 32,
   parameter int DEPTH   = 8,
   parameter int HOLDOFF = 2,
   localparam int IDW    = (NCALL > 1) ? $clog2(NCALL) : 1,
   localparam int PW     = $clog2(DEPTH),
   localparam int CW     = $clog2(HOLDOFF + 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCALL-1:0]      call_s,
   input  logic [NCALL*ARGW-1:0] call_arg,
   output logic                  stop_req,
   axis_tbcall_queue_if.master   host,
   output logic [PW:0]           pending,
   output logic [NCALL-1:0]      overflow
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [NCALL-1:0]  prev, pend, edg, grant, pend_nx;
   logic [ARGW-1:0]   parg [NCALL];
   logic [IDW-1:0]    mem_id  [DEPTH];
   logic [ARGW-1:0]   mem_arg [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [PW:0]       count, count_nx;
   logic              empty, full, pop, push, busy_nx;
   logic [IDW-1:0]    gid;

   always_comb begin
      edg        = call_s & ~prev;
      empty      = (count == '0);
      full       = (count == (PW+1)'(DEPTH));
      host.valid = (state == ISSUE) && !empty;
      host.id    = mem_id[rd_ptr];
      host.arg   = mem_arg[rd_ptr];
      pop        = host.valid & host.ack;
      // A full queue still accepts a push when the head retires in the same cycle.
      push       = (|pend) && (!full || pop);
      gid        = '0;
      for (int i = NCALL-1; i >= 0; i--)
         if (pend[i]) gid = IDW'(i);
      grant      = push ? (pend & (~pend + NCALL'(1))) : '0;
      pend_nx    = (pend & ~grant) | edg;
      count_nx   = count + (PW+1)'(push) - (PW+1)'(pop);
      busy_nx    = (|pend_nx) || (count_nx != '0);
      pending    = count;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev     <= '1;
         pend     <= '0;
         overflow <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         state    <= IDLE;
         cnt      <= '0;
         stop_req <= 1'b0;
         for (int i = 0; i < NCALL; i++) parg[i] <= '0;
         for (int d = 0; d < DEPTH; d++) begin
            mem_id[d]  <= '0;
            mem_arg[d] <= '0;
         end
      end else begin
         prev     <= call_s;
         pend     <= pend_nx;
         overflow <= overflow | (edg & pend & ~grant);
         for (int i = 0; i < NCALL; i++)
            if (edg[i] && (!pend[i] || grant[i])) parg[i] <= call_arg[i*ARGW +: ARGW];
         if (push) begin
            mem_id[wr_ptr]  <= gid;
            mem_arg[wr_ptr] <= parg[gid];
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nx;

         // Decisions look at next-cycle occupancy so the holdoff starts as the last call retires.
         case (state)
            IDLE: if (busy_nx) begin
               state    <= ISSUE;
               stop_req <= 1'b1;
            end
            ISSUE: if (!busy_nx) begin
               if (HOLDOFF == 0) begin
                  state    <= IDLE;
                  stop_req <= 1'b0;
               end else begin
                  state <= HOLD;
                  cnt   <= CW'(HOLDOFF);
               end
            end
            HOLD: begin
               if (busy_nx) state <= ISSUE;
               else if (cnt == CW'(1)) begin
                  state    <= IDLE;
                  stop_req <= 1'b0;
               end else cnt <= cnt - 1'b1;
            end
            default: begin
               state    <= IDLE;
               stop_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_tbcall_queue.sv
// Directed bench: one DUT with an 8-deep queue, one with a 2-deep queue for full/stall cases.
module tb_axis_tbcall_queue;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [3:0]   call_s, call_s2;
   logic [127:0] call_arg, call_arg2;
   logic         stop_req, stop_req2;
   logic [3:0]   pending;
   logic [1:0]   pending2;
   logic [3:0]   ovf, ovf2;
   int total = 0, bad = 0;

   axis_tbcall_queue_if #(.IDW(2), .ARGW(32)) h  ();
   axis_tbcall_queue_if #(.IDW(2), .ARGW(32)) h2 ();

   axis_tbcall_queue #(.NCALL(4), .ARGW(32), .DEPTH(8), .HOLDOFF(2)) u_dut (
      .clk(clk), .rst(rst), .call_s(call_s), .call_arg(call_arg), .stop_req(stop_req),
      .host(h), .pending(pending), .overflow(ovf));

   axis_tbcall_queue #(.NCALL(4), .ARGW(32), .DEPTH(2), .HOLDOFF(2)) u_dut2 (
      .clk(clk), .rst(rst), .call_s(call_s2), .call_arg(call_arg2), .stop_req(stop_req2),
      .host(h2), .pending(pending2), .overflow(ovf2));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; call_s = '0; call_s2 = '0; call_arg = '0; call_arg2 = '0;
      h.ack = 1'b0; h2.ack = 1'b0;
      repeat (3) tick();
      total++; if (stop_req !== 1'b0) begin bad++; $display("FAIL rst_stop got=%0b exp=0", stop_req); end
      total++; if (h.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", h.valid); end
      total++; if (h.id !== 2'd0 || h.arg !== 32'd0) begin bad++; $display("FAIL rst_head got id=%0d arg=%h exp 0/0", h.id, h.arg); end
      total++; if (pending !== 4'd0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", pending); end
      total++; if (ovf !== 4'd0 || ovf2 !== 4'd0) begin bad++; $display("FAIL rst_ovf got=%b/%b exp=0", ovf, ovf2); end
      total++; if (stop_req2 !== 1'b0 || pending2 !== 2'd0) begin bad++; $display("FAIL rst_dut2 got stop=%0b pend=%0d exp 0/0", stop_req2, pending2); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_single;
      call_arg[64 +: 32] = 32'hA5A5_0002; call_s = 4'b0100;
      tick();
      total++; if (stop_req !== 1'b1) begin bad++; $display("FAIL t1_stop_n1 got=%0b exp=1", stop_req); end
      total++; if (h.valid !== 1'b0) begin bad++; $display("FAIL t1_valid_n1 got=%0b exp=0", h.valid); end
      tick();
      total++; if (h.valid !== 1'b1 || h.id !== 2'd2 || h.arg !== 32'hA5A5_0002) begin bad++;
         $display("FAIL t1_head got v=%0b id=%0d arg=%h exp v=1 id=2 arg=a5a50002", h.valid, h.id, h.arg); end
      tick();
      total++; if (h.valid !== 1'b1 || h.id !== 2'd2 || pending !== 4'd1) begin bad++;
         $display("FAIL t1_stable got v=%0b id=%0d pend=%0d exp 1/2/1", h.valid, h.id, pending); end
      h.ack = 1'b1; tick(); h.ack = 1'b0;
      total++; if (h.valid !== 1'b0 || stop_req !== 1'b1) begin bad++;
         $display("FAIL t1_ack got v=%0b stop=%0b exp v=0 stop=1", h.valid, stop_req); end
      tick();
      total++; if (stop_req !== 1'b1) begin bad++; $display("FAIL t1_hold1 got=%0b exp=1", stop_req); end
      tick();
      total++; if (stop_req !== 1'b0) begin bad++; $display("FAIL t1_release got=%0b exp=0", stop_req); end
      call_s = '0; tick();
   endtask

   task automatic test_order;
      logic [1:0]  exp_id [3];
      logic [31:0] exp_arg [3];
      exp_id  = '{2'd0, 2'd1, 2'd3};
      exp_arg = '{32'hC0C0_0000, 32'hC1C1_0001, 32'hC3C3_0003};
      call_arg = {32'hC3C3_0003, 32'h0, 32'hC1C1_0001, 32'hC0C0_0000};
      call_s = 4'b1011;
      repeat (4) tick();
      total++; if (pending !== 4'd3) begin bad++; $display("FAIL t2_peak got=%0d exp=3", pending); end
      for (int k = 0; k < 3; k++) begin
         total++; if (h.valid !== 1'b1 || h.id !== exp_id[k] || h.arg !== exp_arg[k]) begin bad++;
            $display("FAIL t2_call%0d got v=%0b id=%0d arg=%h exp id=%0d arg=%h", k, h.valid, h.id, h.arg, exp_id[k], exp_arg[k]); end
         h.ack = 1'b1; tick(); h.ack = 1'b0;
      end
      total++; if (pending !== 4'd0 || ovf !== 4'd0) begin bad++; $display("FAIL t2_drain got pend=%0d ovf=%b exp 0/0", pending, ovf); end
      repeat (2) tick();
      total++; if (stop_req !== 1'b0) begin bad++; $display("FAIL t2_release got=%0b exp=0", stop_req); end
      call_s = '0; tick();
   endtask

   task automatic test_hold_reenter;
      call_arg[0 +: 32] = 32'h0000_1111; call_s = 4'b0001;
      tick(); call_s = '0; tick();
      total++; if (h.valid !== 1'b1 || h.id !== 2'd0 || h.arg !== 32'h0000_1111) begin bad++;
         $display("FAIL t5_first got v=%0b id=%0d arg=%h exp 1/0/00001111", h.valid, h.id, h.arg); end
      h.ack = 1'b1; tick(); h.ack = 1'b0;
      tick();
      total++; if (stop_req !== 1'b1) begin bad++; $display("FAIL t5_hold got=%0b exp=1", stop_req); end
      call_arg[0 +: 32] = 32'h0000_2222; call_s = 4'b0001;
      tick();
      total++; if (stop_req !== 1'b1 || h.valid !== 1'b0) begin bad++;
         $display("FAIL t5_reenter got stop=%0b v=%0b exp 1/0", stop_req, h.valid); end
      tick();
      total++; if (stop_req !== 1'b1 || h.valid !== 1'b1 || h.arg !== 32'h0000_2222) begin bad++;
         $display("FAIL t5_second got stop=%0b v=%0b arg=%h exp 1/1/00002222", stop_req, h.valid, h.arg); end
      h.ack = 1'b1; tick(); h.ack = 1'b0;
      repeat (2) tick();
      total++; if (stop_req !== 1'b0) begin bad++; $display("FAIL t5_release got=%0b exp=0", stop_req); end
      call_s = '0; tick();
   endtask

   task automatic test_full;
      call_arg2 = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
      call_s2 = 4'b1111;
      repeat (4) tick();
      total++; if (pending2 !== 2'd2 || h2.id !== 2'd0) begin bad++;
         $display("FAIL t3_full got pend=%0d id=%0d exp 2/0", pending2, h2.id); end
      for (int k = 0; k < 4; k++) begin
         total++; if (h2.valid !== 1'b1 || h2.id !== 2'(k) || h2.arg !== {8'hD0 + 8'(k), 8'hD0 + 8'(k), 16'(k)}) begin bad++;
            $display("FAIL t3_call%0d got v=%0b id=%0d arg=%h", k, h2.valid, h2.id, h2.arg); end
         h2.ack = 1'b1; tick(); h2.ack = 1'b0;
      end
      total++; if (pending2 !== 2'd0 || ovf2 !== 4'd0) begin bad++; $display("FAIL t3_drain got pend=%0d ovf=%b exp 0/0", pending2, ovf2); end
      repeat (2) tick();
      total++; if (stop_req2 !== 1'b0) begin bad++; $display("FAIL t3_release got=%0b exp=0", stop_req2); end
      call_s2 = '0; tick();
   endtask

   task automatic test_overflow;
      logic [1:0]  exp_id [3];
      logic [31:0] exp_arg [3];
      exp_id  = '{2'd0, 2'd2, 2'd1};
      exp_arg = '{32'hE0E0_0000, 32'hE2E2_0002, 32'hE1E1_0001};
      call_arg2 = {32'h0, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000};
      call_s2 = 4'b0101;
      repeat (3) tick();
      call_s2 = 4'b0111; tick();
      total++; if (pending2 !== 2'd2 || ovf2 !== 4'd0) begin bad++;
         $display("FAIL t4_stall got pend=%0d ovf=%b exp 2/0000", pending2, ovf2); end
      call_s2 = 4'b0101; tick();
      call_arg2[32 +: 32] = 32'hBAD0_0001; call_s2 = 4'b0111; tick();
      total++; if (ovf2 !== 4'b0010) begin bad++; $display("FAIL t4_ovf got=%b exp=0010", ovf2); end
      for (int k = 0; k < 3; k++) begin
         total++; if (h2.valid !== 1'b1 || h2.id !== exp_id[k] || h2.arg !== exp_arg[k]) begin bad++;
            $display("FAIL t4_call%0d got v=%0b id=%0d arg=%h exp id=%0d arg=%h", k, h2.valid, h2.id, h2.arg, exp_id[k], exp_arg[k]); end
         h2.ack = 1'b1; tick(); h2.ack = 1'b0;
      end
      repeat (5) tick();
      total++; if (h2.valid !== 1'b0 || stop_req2 !== 1'b0 || pending2 !== 2'd0) begin bad++;
         $display("FAIL t4_single got v=%0b stop=%0b pend=%0d exp 0/0/0", h2.valid, stop_req2, pending2); end
      total++; if (ovf2 !== 4'b0010) begin bad++; $display("FAIL t4_sticky got=%b exp=0010", ovf2); end
      call_s2 = '0; tick();
   endtask

   task automatic test_reset_mid;
      call_arg = {32'h0, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
      call_s = 4'b0111;
      repeat (4) tick();
      total++; if (pending !== 4'd3 || stop_req !== 1'b1 || h.valid !== 1'b1) begin bad++;
         $display("FAIL t6_pre got pend=%0d stop=%0b v=%0b exp 3/1/1", pending, stop_req, h.valid); end
      rst = 1'b1; tick();
      total++; if (stop_req !== 1'b0 || h.valid !== 1'b0 || h.id !== 2'd0 || h.arg !== 32'd0 || pending !== 4'd0 || ovf !== 4'd0) begin bad++;
         $display("FAIL t6_rst got stop=%0b v=%0b id=%0d arg=%h pend=%0d ovf=%b exp all 0", stop_req, h.valid, h.id, h.arg, pending, ovf); end
      total++; if (ovf2 !== 4'd0) begin bad++; $display("FAIL t6_ovf2 got=%b exp=0000", ovf2); end
      rst = 1'b0;
      repeat (4) tick();
      total++; if (stop_req !== 1'b0 || pending !== 4'd0) begin bad++;
         $display("FAIL t6_noretrig got stop=%0b pend=%0d exp 0/0", stop_req, pending); end
      call_s = '0; tick();
      call_arg[0 +: 32] = 32'h0000_6666; call_s = 4'b0001; tick();
      total++; if (stop_req !== 1'b1) begin bad++; $display("FAIL t6_new_stop got=%0b exp=1", stop_req); end
      tick();
      total++; if (h.valid !== 1'b1 || h.id !== 2'd0 || h.arg !== 32'h0000_6666) begin bad++;
         $display("FAIL t6_new_call got v=%0b id=%0d arg=%h exp 1/0/00006666", h.valid, h.id, h.arg); end
      h.ack = 1'b1; tick(); h.ack = 1'b0;
      repeat (2) tick();
      total++; if (stop_req !== 1'b0) begin bad++; $display("FAIL t6_release got=%0b exp=0", stop_req); end
      call_s = '0; tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_order();
      test_hold_reenter();
      test_full();
      test_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
